node_scheduler: RTL

- Time-multiplexes one shared node datapath (2 multipliers + adder, WIDTH-bit) across NUM_NODES logical neurons of a layer.
- Each neuron computes result[i] = x*wa[i] + y*wb[i], using the node's own truncating WIDTH-bit arithmetic.
- Owns the per-neuron weight bank, accepts one (x,y) sample per layer pass, and streams NUM_NODES results out with valid/ready.
- Sits between the sample source and the next layer; the node instance sits beside it, driven by the node_* ports.

---
 rtl/node_pkg.sv | 15 +
 rtl/node_weight_bank.sv | 55 +++++
 rtl/node_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared types for the node scheduler: datapath width default, FSM states, index type.
package node_pkg;

    localparam int NODE_WIDTH = 10;
    localparam int NODE_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } sched_state_t;

    typedef logic [NODE_IDX_W-1:0] node_idx_t;

endpackage

// File: rtl/node_weight_bank.sv
// Per-neuron weight pair storage: one gated write port, one combinational read port on idx.
module node_weight_bank
    import node_pkg::*;
#(
    parameter int WIDTH     = NODE_WIDTH,
    parameter int NUM_NODES = 4,
    parameter int IDX_W     = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wa,
    input  logic [WIDTH-1:0] i_wb,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [WIDTH-1:0] o_wa,
    output logic [WIDTH-1:0] o_wb
);

    logic [WIDTH-1:0] w_wa_q [NUM_NODES];
    logic [WIDTH-1:0] w_wb_q [NUM_NODES];

    // Addresses with no matching entry (>= NUM_NODES) simply never hit a slot.
    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : gen_entry
            logic [WIDTH-1:0] r_wa;
            logic [WIDTH-1:0] r_wb;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wa <= '0;
                    r_wb <= '0;
                end else if (i_we && (i_waddr == IDX_W'(gi))) begin
                    r_wa <= i_wa;
                    r_wb <= i_wb;
                end
            end

            assign w_wa_q[gi] = r_wa;
            assign w_wb_q[gi] = r_wb;
        end
    endgenerate

    always_comb begin
        o_wa = '0;
        o_wb = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (i_ridx == IDX_W'(i)) begin
                o_wa = w_wa_q[i];
                o_wb = w_wb_q[i];
            end
        end
    end

endmodule

// File: rtl/node_scheduler.sv
// Time-multiplexes one external node datapath over NUM_NODES neurons per sample.
// Optional build macro NODE_SCHED_RELU_EN clamps negative node results to zero on capture.
module node_scheduler
    import node_pkg::*;
#(
    parameter int WIDTH     = NODE_WIDTH,
    parameter int NUM_NODES = 4,
    parameter int IDX_W     = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_wa,
    input  logic [WIDTH-1:0] cfg_wb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] node_a,
    output logic [WIDTH-1:0] node_b,
    output logic [WIDTH-1:0] node_multA,
    output logic [WIDTH-1:0] node_multB,
    input  logic [WIDTH-1:0] node_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_out_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_done;
    logic [WIDTH-1:0] w_wa;
    logic [WIDTH-1:0] w_wb;
    logic [WIDTH-1:0] w_capture;
    logic             w_cfg_we;
    logic             w_last;

    // Weight writes only land while idle, so a pass always sees one consistent bank.
    assign w_cfg_we = cfg_we && (r_state == IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    node_weight_bank #(
        .WIDTH     (WIDTH),
        .NUM_NODES (NUM_NODES),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_cfg_we),
        .i_waddr (cfg_addr),
        .i_wa    (cfg_wa),
        .i_wb    (cfg_wb),
        .i_ridx  (r_idx),
        .o_wa    (w_wa),
        .o_wb    (w_wb)
    );

`ifdef NODE_SCHED_RELU_EN
    assign w_capture = node_result[WIDTH-1] ? '0 : node_result;
`else
    assign w_capture = node_result;
`endif

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        node_a       = '0;
        node_b       = '0;
        node_multA   = '0;
        node_multB   = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy         = 1'b1;
                node_a       = r_x;
                node_b       = r_y;
                node_multA   = w_wa;
                node_multB   = w_wb;
                w_state_next = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
                if (out_ready) begin
                    w_state_next = w_last ? IDLE : COMPUTE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x   <= in_x;
                        r_y   <= in_y;
                        r_idx <= '0;
                    end
                end
                COMPUTE: begin
                    r_out_data  <= w_capture;
                    r_out_idx   <= r_idx;
                    r_out_valid <= 1'b1;
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule
